im_fetch_sequencer: RTL
=======================

// Module: im_fetch_sequencer
// PURPOSE
//  Sequences the MAC-engine instruction memory: drives PC, captures each 64-bit instruction, issues it to the
//  engine over a valid/ready handshake, handles END and single-level JUMP/repeat opcodes, and gates the external
//  IM write port so the program cannot be rewritten while it runs. Sits between the config bus/IM and the engine decoder.
// PARAMETERS
//  IM_SIZE    2   instruction words in IM (PC range 0..IM_SIZE-1)
//  IM_FIELDS  2   32-bit fields per instruction
//  IM_WIDTH   32  field width; instruction = IM_FIELDS*IM_WIDTH bits
//  EXT_W      32  external port width
// PORTS
//  clk             in   1      clock
//  reset           in   1      synchronous reset, active-high
//  start           in   1      pulse: run program from PC=0 (ignored unless IDLE)
//  busy            out  1      high in any state other than IDLE
//  done            out  1      one-cycle pulse at program end
//  error           out  1      sticky: overrun or bad jump target; cleared by next accepted start
//  wr_en_ext_in    in   1      config-bus IM write enable
//  wr_addr_ext_in  in   EXT_W  config-bus IM write address (word*2+field)
//  wr_data_ext_in  in   EXT_W  config-bus IM write data
//  wr_en_ext_im    out  1      to IM: wr_en_ext_in & ~busy
//  wr_addr_ext_im  out  EXT_W  to IM: pass-through of wr_addr_ext_in
//  wr_data_ext_im  out  EXT_W  to IM: pass-through of wr_data_ext_in
//  wr_reject       out  1      registered pulse, cycle after a write arrives while busy (write dropped)
//  PC              out  32     IM read address (combinational IM read)
//  instruction     in   IM_FIELDS*IM_WIDTH  IM read data for PC
//  instr_valid     out  1      instr_out valid to engine
//  instr_ready     in   1      engine accepts instr_out
//  instr_out       out  IM_FIELDS*IM_WIDTH  registered instruction
// BEHAVIOUR
//  Reset: state IDLE, PC=0, instr_out=0, instr_valid=0, busy=0, done=0, error=0, wr_reject=0, loop state cleared.
//  Reset mid-run aborts immediately; no done pulse.
//  Opcode = instruction[31:28] (field0). 4'hF END; 4'hE JUMP (cnt=[27:16], target=[15:0]); others issued verbatim.
//  FSM: IDLE -> FETCH on start (PC<=0, error<=0).
//   FETCH: decode instruction at PC (registered into instr_out for issue).
//    END -> DONE (not issued).
//    JUMP (not issued): target>=IM_SIZE -> error<=1, DONE. Else if !loop_active: cnt==0 -> PC+1;
//     else loop_active<=1, loop_cnt<=cnt-1, PC<=target. If loop_active: loop_cnt==0 -> loop_active<=0,
//     PC+1; else loop_cnt--, PC<=target. Stay in FETCH. Body runs cnt+1 times; no nesting.
//    JUMP/END PC+1 at PC==IM_SIZE-1 -> error<=1, DONE.
//    other -> ISSUE, instr_valid<=1.
//   ISSUE: hold instr_out/instr_valid until instr_ready. On handshake: instr_valid<=0; PC==IM_SIZE-1 -> DONE
//    with error<=1 (no END); else PC<=PC+1, FETCH.
//   DONE: done=1 one cycle, loop state cleared, -> IDLE. PC holds last value.
//  Latency: start sampled at edge 0 -> FETCH cycle 1 -> instr_valid cycle 2. Max throughput 1 instr / 2 cycles.
//  Start while busy: ignored. Start and write same cycle in IDLE: write forwarded; fetch reads updated word.
//  Writes forwarded combinationally in IDLE only (busy=0); DONE counts as busy.
//  instr_valid never drops without instr_ready; instr_out stable while valid.
// STRUCTURE
//  Package im_seq_pkg: opcode constants (OP_END, OP_JUMP), field bit positions, state enum
//  {IDLE,FETCH,ISSUE,DONE}, IM_SIZE/IM_WIDTH defaults.
//  One sub-module: im_loop_counter (loop_active, loop_cnt, load/decrement/expire decision).
// TESTING
//  1 IM={ADD 0x1000_0001, END}; start, ready=1 -> one issue of word0 at cycle 2, done at cycle 5, error=0.
//  2 Backpressure: ready=0 for 5 cycles in ISSUE -> instr_valid/instr_out stable, PC unchanged; completes on ready.
//  3 IM_SIZE=4: {A, B, JUMP cnt=2 tgt=0, END} -> issue order A,B,A,B,A,B then done; loop_active=0 after.
//  4 No END: IM={A,B} -> A,B issued, done with error=1; next start clears error.
//  5 Write while busy -> wr_en_ext_im=0, wr_reject pulses next cycle, IM contents unchanged; in IDLE forwarded.
//  6 Reset asserted in ISSUE -> next cycle IDLE, instr_valid=0, PC=0, no done; start while busy ignored.

Source files
------------

// File: rtl/im_fetch_sequencer_pkg.sv
// Shared constants, opcode encodings and the sequencer state type for the
// MAC-engine instruction-memory fetch path.
package im_seq_pkg;

    localparam int unsigned IM_SIZE_DEF   = 2;
    localparam int unsigned IM_FIELDS_DEF = 2;
    localparam int unsigned IM_WIDTH_DEF  = 32;
    localparam int unsigned EXT_W_DEF     = 32;

    localparam logic [3:0] OP_END  = 4'hF;
    localparam logic [3:0] OP_JUMP = 4'hE;

    // Field positions inside field0 of an instruction
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 28;
    localparam int unsigned CNT_HI = 27;
    localparam int unsigned CNT_LO = 16;
    localparam int unsigned TGT_HI = 15;
    localparam int unsigned TGT_LO = 0;

    localparam int unsigned CNT_W = CNT_HI - CNT_LO + 1;
    localparam int unsigned TGT_W = TGT_HI - TGT_LO + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/im_fetch_sequencer_loop_counter.sv
// Single-level repeat state for JUMP: decides whether a jump is taken and
// tracks the remaining passes of the active loop body.
module im_loop_counter
    import im_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_take
);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;

    // An idle loop arms from the opcode count; an active one uses what is left
    assign o_take = r_active ? (r_cnt != '0) : (i_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_step) begin
            if (!r_active) begin
                if (i_cnt != '0) begin
                    r_active <= 1'b1;
                    r_cnt    <= i_cnt - 1'b1;
                end
            end else if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/im_fetch_sequencer.sv
// Instruction-memory sequencer: walks PC, issues instructions over valid/ready,
// handles END/JUMP and blocks config-bus IM writes while a program runs.
module im_fetch_sequencer
    import im_seq_pkg::*;
#(
    parameter int unsigned IM_SIZE   = IM_SIZE_DEF,
    parameter int unsigned IM_FIELDS = IM_FIELDS_DEF,
    parameter int unsigned IM_WIDTH  = IM_WIDTH_DEF,
    parameter int unsigned EXT_W     = EXT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    input  logic                          wr_en_ext_in,
    input  logic [EXT_W-1:0]              wr_addr_ext_in,
    input  logic [EXT_W-1:0]              wr_data_ext_in,
    output logic                          wr_en_ext_im,
    output logic [EXT_W-1:0]              wr_addr_ext_im,
    output logic [EXT_W-1:0]              wr_data_ext_im,
    output logic                          wr_reject,
    output logic [31:0]                   PC,
    input  logic [IM_FIELDS*IM_WIDTH-1:0] instruction,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [IM_FIELDS*IM_WIDTH-1:0] instr_out
);

    seq_state_t                  r_state;
    logic [31:0]                 r_pc;
    logic [IM_FIELDS*IM_WIDTH-1:0] r_instr;
    logic                        r_valid;
    logic                        r_done;
    logic                        r_error;
    logic                        r_wr_reject;

    logic [3:0]       w_op;
    logic [CNT_W-1:0] w_cnt;
    logic [TGT_W-1:0] w_tgt;
    logic             w_last;
    logic             w_tgt_bad;
    logic             w_jump_step;
    logic             w_take;
    logic             w_busy;

    assign w_op      = instruction[OPC_HI:OPC_LO];
    assign w_cnt     = instruction[CNT_HI:CNT_LO];
    assign w_tgt     = instruction[TGT_HI:TGT_LO];
    assign w_last    = (r_pc == 32'(IM_SIZE - 1));
    assign w_tgt_bad = ({16'd0, w_tgt} >= 32'(IM_SIZE));
    assign w_busy    = (r_state != IDLE);

    // Loop state only advances on a JUMP whose target is in range
    assign w_jump_step = (r_state == FETCH) && (w_op == OP_JUMP) && !w_tgt_bad;

    im_loop_counter u_loop (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state == DONE),
        .i_step  (w_jump_step),
        .i_cnt   (w_cnt),
        .o_take  (w_take)
    );

    assign busy           = w_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign wr_en_ext_im   = wr_en_ext_in & ~w_busy;
    assign wr_addr_ext_im = wr_addr_ext_in;
    assign wr_data_ext_im = wr_data_ext_in;
    assign wr_reject      = r_wr_reject;
    assign PC             = r_pc;
    assign instr_valid    = r_valid;
    assign instr_out      = r_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_instr     <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wr_reject <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_wr_reject <= wr_en_ext_in & w_busy;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_pc    <= '0;
                        r_error <= 1'b0;
                    end
                end
                FETCH: begin
                    if (w_op == OP_END) begin
                        r_state <= DONE;
                    end else if (w_op == OP_JUMP) begin
                        if (w_tgt_bad) begin
                            r_error <= 1'b1;
                            r_state <= DONE;
                        end else if (w_take) begin
                            r_pc <= {16'd0, w_tgt};
                        end else if (w_last) begin
                            r_error <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_pc <= r_pc + 32'd1;
                        end
                    end else begin
                        r_instr <= instruction;
                        r_valid <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_error <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_pc    <= r_pc + 32'd1;
                            r_state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    // done is registered here so it pulses the cycle IDLE is reached
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
